des_round_controller: RTL
=========================

// Module: des_round_controller
// PURPOSE
//  Sequencer for the iterative DES core: accepts one post-IP 64-bit block plus key, runs the
//  Feistel rounds one per clock, generates each round subkey, and presents {L16,R16} to
//  FinalPermutation (which performs the final swap). Drives an external combinational Feistel
//  F-function with (RoundR, RoundKey) and consumes its 32-bit result RoundF.
// PARAMETERS
//  ROUNDS   16   rounds per block, legal 1..16; values below 16 are for bench/debug use only
// PORTS
//  Clock       in   1   single clock; all state updates on rising edge
//  Reset       in   1   asynchronous, active-high reset
//  InValid     in   1   input block/key valid
//  InReady     out  1   controller can accept a block (registered)
//  InData      in   64  post-IP block, [1:32]=L0, [33:64]=R0
//  InKey       in   64  DES key incl. parity bits (parity ignored)
//  InDecrypt   in   1   1=decrypt (reverse subkey order), sampled with the block
//  RoundR      out  32  current R half to F-function
//  RoundKey    out  48  current subkey Kn to F-function
//  RoundF      in   32  F(RoundR,RoundKey), combinational return, same cycle
//  RoundIdx    out  4   round being computed, 0..ROUNDS-1
//  Busy        out  1   high in ROUND and DONE
//  OutValid    out  1   OutData valid (registered)
//  OutReady    in   1   downstream accepts OutData
//  OutData     out  64  {L16,R16} unswapped, feeds FinalPermutation
//  Abort       in   1   only when DES_ABORT_EN defined
// BEHAVIOUR
//  Reset (async assert): state=IDLE; InReady, OutValid, Busy=0; OutData, RoundR, RoundKey,
//   RoundIdx, L, R, C, D = 0. InReady rises on the first edge after Reset deasserts.
//  States: IDLE -> ROUND -> DONE -> IDLE.
//  IDLE: InReady=1. On edge with InValid&InReady: L<=InData[1:32], R<=InData[33:64],
//   {C,D}<=PC1(InKey), mode<=InDecrypt, RoundIdx<=0, InReady<=0, Busy<=1, -> ROUND.
//  ROUND cycle k: encrypt: CDk=rotl28(C,D by SHIFT[k]), RoundKey=PC2(CDk), stored CD<=CDk.
//   Decrypt: RoundKey=PC2(C,D), stored CD<=rotr28(C,D by SHIFT[15-k]) (yields K16..K1).
//   RoundR=R. At edge: L<=R, R<=L^RoundF, RoundIdx<=k+1.
//  After edge of k=ROUNDS-1: OutData<={L,R} (post-round values), OutValid<=1, -> DONE.
//  Latency: accept edge t -> OutValid high after edge t+ROUNDS. Throughput 1 block/(ROUNDS+2) clk.
//  DONE: OutData/OutValid held stable until OutReady=1; on that edge OutValid<=0, C,D,L,R<=0
//   (key scrub), Busy<=0, InReady<=1, -> IDLE. InValid during ROUND/DONE is not accepted.
//  SHIFT = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}; rotations modulo 28, per half.
//  ROUNDS<16 with decrypt still starts at K16: not an inverse, debug only.
//  Reset mid-operation: immediate return to IDLE, block discarded, OutValid never asserted.
// CONFIGURATION
//  DES_ABORT_EN defined: Abort port exists; Abort=1 sampled in ROUND or DONE -> next edge
//   IDLE with same scrub as DONE exit, OutValid<=0, no output delivered; ignored in IDLE.
//  Not defined: no Abort port; every accepted block runs to completion.
// STRUCTURE
//  Package des_pkg: PC1 and PC2 tables, SHIFT schedule constant, state enum
//   (IDLE/ROUND/DONE), width constants (BLK_W=64, HALF_W=32, KEY_W=48, CD_W=28).
//  Sub-module des_key_schedule: holds C/D, performs PC1 load, enc/dec rotation, PC2 output;
//   controller FSM, L/R registers and handshakes stay in des_round_controller.
// TESTING
//  Bench instantiates team InitialPermutation, F-function and FinalPermutation around DUT.
//  1 Key 133457799BBCDFF1, pt 0123456789ABCDEF, enc -> RoundKey k=0 1B02EFFC7072, k=15
//    CB3D8B0E17F5; final ciphertext 85E813540F0AB405; OutValid exactly 16 edges post-accept.
//  2 Same key, ct 85E813540F0AB405, decrypt -> RoundKey k=0 CB3D8B0E17F5; pt 0123456789ABCDEF.
//  3 OutReady held low 10 cycles in DONE -> OutData/OutValid stable, InReady=0, new InValid
//    ignored; OutReady pulse -> InReady=1 next cycle, next block accepted.
//  4 Reset asserted at RoundIdx=7 -> all outputs 0 asynchronously, no OutValid; next block
//    after release gives correct result.
//  5 Back-to-back 100 random key/block pairs vs reference model, random OutReady stalls;
//    verify C,D,L,R read 0 in IDLE after each block.
//  6 DES_ABORT_EN: Abort at RoundIdx=3 -> IDLE next edge, OutValid stays 0; Abort in IDLE no effect.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES sequencer definitions: widths, PC1/PC2 selection tables, shift schedule,
// controller state type and 28-bit half rotation helpers.
package des_pkg;
    localparam int BLK_W  = 64;
    localparam int HALF_W = 32;
    localparam int KEY_W  = 48;
    localparam int CD_W   = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Table entries are DES bit numbers: 1 is the MSB of the source vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
    endfunction
endpackage

// File: rtl/des_round_controller_if.sv
// Block/key handshake, F-function and output bus of the DES round controller.
// The abort request line exists only when DES_ABORT_EN is defined.
interface des_round_controller_if;
    import des_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BLK_W-1:0]  in_data;
    logic [BLK_W-1:0]  in_key;
    logic              in_decrypt;
    logic [HALF_W-1:0] round_r;
    logic [KEY_W-1:0]  round_key;
    logic [HALF_W-1:0] round_f;
    logic [3:0]        round_idx;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [BLK_W-1:0]  out_data;
`ifdef DES_ABORT_EN
    logic              abort;

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, round_f, out_ready, abort,
        output in_ready, round_r, round_key, round_idx, busy, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, in_key, in_decrypt, round_f, out_ready, abort,
        input  in_ready, round_r, round_key, round_idx, busy, out_valid, out_data
    );
`else
    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, round_f, out_ready,
        output in_ready, round_r, round_key, round_idx, busy, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, in_key, in_decrypt, round_f, out_ready,
        input  in_ready, round_r, round_key, round_idx, busy, out_valid, out_data
    );
`endif
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: PC1 load of C/D, per-round rotation (left when encrypting,
// right when decrypting so subkeys come out K16..K1) and PC2 subkey output.
module des_key_schedule
    import des_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [BLK_W-1:0] i_key,
    input  logic             i_decrypt,
    input  logic             i_step,
    input  logic             i_scrub,
    input  logic [3:0]       i_round_idx,
    output logic [KEY_W-1:0] o_round_key
);
    logic [2*CD_W-1:0] w_pc1;
    logic [2*CD_W-1:0] w_cd_sel;
    logic [CD_W-1:0]   w_c_enc, w_d_enc, w_c_dec, w_d_dec;
    logic [1:0]        w_enc_shift, w_dec_shift;
    logic [CD_W-1:0]   r_c, r_d;
    logic              r_decrypt;
    logic              w_unused_bits;

    generate
        for (genvar gi = 0; gi < 2*CD_W; gi++) begin : g_pc1
            assign w_pc1[2*CD_W-1-gi] = i_key[BLK_W - PC1_TAB[gi]];
        end
    endgenerate

    assign w_enc_shift = SHIFT_TAB[i_round_idx];
    assign w_dec_shift = SHIFT_TAB[4'd15 - i_round_idx];
    assign w_c_enc     = rotl28(r_c, w_enc_shift);
    assign w_d_enc     = rotl28(r_d, w_enc_shift);
    assign w_c_dec     = rotr28(r_c, w_dec_shift);
    assign w_d_dec     = rotr28(r_d, w_dec_shift);

    // Encrypt rotates before use; decrypt uses the stored value and rotates afterwards.
    assign w_cd_sel = r_decrypt ? {r_c, r_d} : {w_c_enc, w_d_enc};

    generate
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_pc2
            assign o_round_key[KEY_W-1-gi] = w_cd_sel[2*CD_W - PC2_TAB[gi]];
        end
    endgenerate

    // Key parity bits and the C/D bits PC2 drops have no function here.
    assign w_unused_bits = ^{i_key, w_cd_sel};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c       <= '0;
            r_d       <= '0;
            r_decrypt <= 1'b0;
        end else if (i_load) begin
            r_c       <= w_pc1[2*CD_W-1:CD_W];
            r_d       <= w_pc1[CD_W-1:0];
            r_decrypt <= i_decrypt;
        end else if (i_scrub) begin
            r_c <= '0;
            r_d <= '0;
        end else if (i_step) begin
            if (r_decrypt) begin
                r_c <= w_c_dec;
                r_d <= w_d_dec;
            end else begin
                r_c <= w_c_enc;
                r_d <= w_d_enc;
            end
        end
    end
endmodule

// File: rtl/des_round_controller.sv
// Iterative DES round sequencer: one Feistel round per clock through an external
// F-function, {L16,R16} presented unswapped. DES_ABORT_EN enables the abort request.
module des_round_controller
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    des_round_controller_if.slave   io_bus
);
    state_t            r_state;
    logic [HALF_W-1:0] r_l, r_r;
    logic [3:0]        r_round_idx;
    logic              r_in_ready, r_busy, r_out_valid;
    logic [BLK_W-1:0]  r_out_data;
    logic              w_accept, w_last, w_scrub, w_abort;
    logic [HALF_W-1:0] w_r_next;

`ifdef DES_ABORT_EN
    assign w_abort = io_bus.abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && io_bus.in_valid && r_in_ready;
    assign w_last   = (r_round_idx == 4'(ROUNDS - 1));
    assign w_scrub  = w_abort || ((r_state == DONE) && io_bus.out_ready);
    assign w_r_next = r_l ^ io_bus.round_f;

    des_key_schedule u_ks (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_accept),
        .i_key       (io_bus.in_key),
        .i_decrypt   (io_bus.in_decrypt),
        .i_step      (r_state == ROUND),
        .i_scrub     (w_scrub),
        .i_round_idx (r_round_idx),
        .o_round_key (io_bus.round_key)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_l         <= '0;
            r_r         <= '0;
            r_round_idx <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_scrub) begin
            // Leaving DONE or aborting clears the block halves along with C/D.
            r_state     <= IDLE;
            r_l         <= '0;
            r_r         <= '0;
            r_round_idx <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_l         <= io_bus.in_data[BLK_W-1:HALF_W];
                        r_r         <= io_bus.in_data[HALF_W-1:0];
                        r_round_idx <= '0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ROUND;
                    end
                end
                ROUND: begin
                    r_l         <= r_r;
                    r_r         <= w_r_next;
                    r_round_idx <= r_round_idx + 4'd1;
                    if (w_last) begin
                        r_out_data  <= {r_r, w_r_next};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: ;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.busy      = r_busy;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.round_r   = r_r;
    assign io_bus.round_idx = r_round_idx;
endmodule
